// File: rtl/uart_tx_driver.sv
// rtl/uart_tx_driver.sv - 8N1 serial transmitter with a small byte FIFO, driving the chip ser_rx pin
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module uart_tx_driver #(
  parameter int CLKS_PER_BIT = 106,
  parameter int FIFO_DEPTH   = 4,
  parameter int FIFO_AW      = 2
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               in_valid,
  input  logic [7:0]         in_data,
  output logic               in_ready,
  output logic               ser_rx,
  output logic               busy,
  output logic               tx_done,
  output logic [FIFO_AW:0]   fifo_level
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0]  BAUD_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [FIFO_AW:0]   LEVEL_FULL = (FIFO_AW + 1)'(FIFO_DEPTH);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_STOP   = 3'd3;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd4;
`endif

  logic [2:0]         r_state;
  logic [BAUD_W-1:0]  r_baud;
  logic [2:0]         r_bit_cnt;
  logic [7:0]         r_sh;
  logic               r_ser_rx;
  logic               r_resetn_q;
  logic [FIFO_AW-1:0] r_wr_ptr;
  logic [FIFO_AW-1:0] r_rd_ptr;
  logic [FIFO_AW:0]   r_level;
  logic [7:0]         r_mem [FIFO_DEPTH];
`ifdef UART_TX_PARITY_EN
  logic               r_parity;
`endif

  logic       w_push;
  logic       w_pop;
  logic       w_bit_end;
  logic       w_stop_end;
  logic [7:0] w_head;

  assign w_bit_end  = (r_baud == BAUD_LAST);
  assign w_stop_end = (r_state == S_STOP) && w_bit_end;
  // The head is popped straight into the shifter, so back-to-back frames need no gap cycle.
  assign w_pop      = (r_level != '0) && ((r_state == S_IDLE) || w_stop_end);
  assign w_push     = in_valid && in_ready;
  assign w_head     = r_mem[r_rd_ptr];

  assign in_ready   = r_resetn_q && (r_level != LEVEL_FULL);
  assign ser_rx     = r_ser_rx;
  assign busy       = (r_state != S_IDLE) || (r_level != '0);
  assign tx_done    = w_stop_end;
  assign fifo_level = r_level;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_resetn_q <= 1'b0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
    end else begin
      r_resetn_q <= 1'b1;
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_level <= r_level + 1'b1;
      else if (!w_push && w_pop) r_level <= r_level - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (resetn && w_push) r_mem[r_wr_ptr] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state   <= S_IDLE;
      r_baud    <= '0;
      r_bit_cnt <= '0;
      r_sh      <= '0;
      r_ser_rx  <= 1'b1;
`ifdef UART_TX_PARITY_EN
      r_parity  <= 1'b0;
`endif
    end else if (w_pop) begin
      r_state  <= S_START;
      r_baud   <= '0;
      r_sh     <= w_head;
      r_ser_rx <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_parity <= ^w_head;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          r_baud   <= '0;
          r_ser_rx <= 1'b1;
        end
        S_START: begin
          if (w_bit_end) begin
            r_baud    <= '0;
            r_bit_cnt <= '0;
            r_ser_rx  <= r_sh[0];
            r_state   <= S_DATA;
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            r_baud <= '0;
            if (r_bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              r_state  <= S_PARITY;
              r_ser_rx <= r_parity;
`else
              r_state  <= S_STOP;
              r_ser_rx <= 1'b1;
`endif
            end else begin
              r_sh      <= {1'b0, r_sh[7:1]};
              r_ser_rx  <= r_sh[1];
              r_bit_cnt <= r_bit_cnt + 3'd1;
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (w_bit_end) begin
            r_baud   <= '0;
            r_ser_rx <= 1'b1;
            r_state  <= S_STOP;
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
`endif
        S_STOP: begin
          if (w_bit_end) begin
            r_baud   <= '0;
            r_ser_rx <= 1'b1;
            r_state  <= S_IDLE;
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        default: begin
          r_state  <= S_IDLE;
          r_baud   <= '0;
          r_ser_rx <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_driver.sv
// tb/tb_uart_tx_driver.sv - randomized bench for uart_tx_driver at dividers 106 and 2 against a frame-timeline model
`timescale 1ns/1ps
module tb_uart_tx_driver;
  localparam int C0    = 106;
  localparam int C1    = 2;
  localparam int DEPTH = 4;
  localparam int CAP   = 32;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS  = 11;
  localparam int DONE55 = 1166;
  localparam int LOW00  = 20;
  localparam int DONE00 = 22;
`else
  localparam int NBITS  = 10;
  localparam int DONE55 = 1060;
  localparam int LOW00  = 18;
  localparam int DONE00 = 20;
`endif
  localparam int FL0 = C0 * NBITS;

  logic       clk      = 1'b0;
  logic       resetn   = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data  = 8'h00;
  logic       rdy0, ser0, busy0, done0;
  logic       rdy1, ser1, busy1, done1;
  logic [2:0] lvl0, lvl1;

  always #5 clk = ~clk;

  uart_tx_driver #(.CLKS_PER_BIT(C0), .FIFO_DEPTH(DEPTH), .FIFO_AW(2)) u_dut0 (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy0), .ser_rx(ser0), .busy(busy0), .tx_done(done0), .fifo_level(lvl0));

  uart_tx_driver #(.CLKS_PER_BIT(C1), .FIFO_DEPTH(DEPTH), .FIFO_AW(2)) u_dut1 (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy1), .ser_rx(ser1), .busy(busy1), .tx_done(done1), .fifo_level(lvl1));

  int cyc      = 0;
  int checks   = 0;
  int failures = 0;

  // Model: each accepted byte gets an accept edge and a frame start cycle; everything else follows.
  int         m_acc [2][CAP];
  int         m_st  [2][CAP];
  logic [7:0] m_dat [2][CAP];
  int         m_n   [2] = '{0, 0};
  bit         m_rq  [2] = '{1'b0, 1'b0};

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  function automatic int cpb(input int k);
    return (k == 0) ? C0 : C1;
  endfunction

  function automatic int m_level(input int k, input int c);
    int l = 0;
    for (int i = 0; i < m_n[k]; i++)
      if (m_acc[k][i] <= c && m_st[k][i] > c) l++;
    return l;
  endfunction

  function automatic bit m_busy(input int k, input int c);
    for (int i = 0; i < m_n[k]; i++)
      if (m_acc[k][i] <= c && m_st[k][i] + cpb(k) * NBITS - 1 >= c) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_done(input int k, input int c);
    for (int i = 0; i < m_n[k]; i++)
      if (m_st[k][i] + cpb(k) * NBITS - 1 == c) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_line(input int k, input int c);
    logic [7:0] d;
    int idx;
    for (int i = 0; i < m_n[k]; i++) begin
      if (c >= m_st[k][i] && c < m_st[k][i] + cpb(k) * NBITS) begin
        idx = (c - m_st[k][i]) / cpb(k);
        d   = m_dat[k][i];
        if (idx == 0) return 1'b0;
        if (idx <= 8) return d[idx-1];
`ifdef UART_TX_PARITY_EN
        if (idx == 9) return ^d;
`endif
        return 1'b1;
      end
    end
    return 1'b1;
  endfunction

  function automatic bit m_ready(input int k, input int c);
    return m_rq[k] && (m_level(k, c) != DEPTH);
  endfunction

  always @(posedge clk) begin
    int e, last_end, fl;
    e = cyc + 1;
    for (int k = 0; k < 2; k++) begin
      fl = cpb(k) * NBITS;
      if (!resetn) begin
        m_n[k] = 0;
      end else begin
        if (in_valid && m_ready(k, cyc) && m_n[k] < CAP) begin
          last_end = (m_n[k] > 0) ? m_st[k][m_n[k]-1] + fl - 1 : -1;
          m_acc[k][m_n[k]] = e;
          m_st[k][m_n[k]]  = (e + 1 > last_end + 1) ? e + 1 : last_end + 1;
          m_dat[k][m_n[k]] = in_data;
          m_n[k]++;
        end
        while (m_n[k] > 0 && m_st[k][0] + fl - 1 < e) begin
          for (int i = 0; i < m_n[k] - 1; i++) begin
            m_acc[k][i] = m_acc[k][i+1];
            m_st[k][i]  = m_st[k][i+1];
            m_dat[k][i] = m_dat[k][i+1];
          end
          m_n[k]--;
        end
      end
      m_rq[k] = resetn;
    end
    cyc = e;
  end

  always @(negedge clk) begin
    if (cyc >= 1) begin
      for (int k = 0; k < 2; k++) begin
        logic [6:0] got, want;
        want = {m_ready(k, cyc), m_line(k, cyc), m_busy(k, cyc), m_done(k, cyc), 3'(m_level(k, cyc))};
        got  = (k == 0) ? {rdy0, ser0, busy0, done0, lvl0} : {rdy1, ser1, busy1, done1, lvl1};
        check($sformatf("model_dut%0d_cyc%0d", k, cyc), got, want);
      end
    end
  end

  task automatic push(input logic [7:0] b, output int e);
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data  = b;
    @(posedge clk); #1;
    e = cyc;
    in_valid = 1'b0;
  endtask

  task automatic wait_to(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  initial begin
    int e, s, acc;
    logic [7:0] b;

    repeat (3) @(negedge clk);
    check("reset_in_ready", rdy0, 1'b0);
    check("reset_ser_rx", ser0, 1'b1);
    check("reset_busy", busy0, 1'b0);
    check("reset_tx_done", done0, 1'b0);
    check("reset_level", lvl0, 3'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
    repeat (3) @(posedge clk); #1;
    check("ready_after_reset", {rdy1, rdy0}, 2'b11);

    // single byte 0x55 on the slow divider
    push(8'h55, e);
    wait_to(e + 1);   check("s55_start_first", ser0, 1'b0);
    wait_to(e + 106); check("s55_start_last", ser0, 1'b0);
    wait_to(e + 107); check("s55_bit0", ser0, 1'b1);
    wait_to(e + 213); check("s55_bit1", ser0, 1'b0);
    wait_to(e + DONE55 - 1); check("s55_no_early_done", done0, 1'b0);
    wait_to(e + DONE55);     check("s55_done", done0, 1'b1);
    wait_to(e + DONE55 + 1); check("s55_idle_busy", busy0, 1'b0);

    // minimum divider, byte 0x00
    push(8'h00, e);
    for (int t = 1; t <= LOW00; t++) begin
      wait_to(e + t);
      check($sformatf("min_low_%0d", t), ser1, 1'b0);
    end
    wait_to(e + LOW00 + 1); check("min_stop_high", ser1, 1'b1);
    wait_to(e + DONE00);    check("min_done", {done1, ser1}, 2'b11);
    wait_to(e + DONE00 + 1); check("min_idle", busy1, 1'b0);
    wait_to(e + FL0 + 5);

    // back-to-back 'A','B' decoded mid-bit from the line
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = 8'h41;
    @(posedge clk); #1;
    e = cyc; in_data = 8'h42;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int f = 0; f < 2; f++) begin
      s = e + 1 + f * FL0;
      wait_to(s); check($sformatf("b2b_start_%0d", f), ser0, 1'b0);
      for (int j = 0; j < 8; j++) begin
        wait_to(s + C0 * (1 + j) + C0 / 2);
        b[j] = ser0;
      end
      wait_to(s + FL0 - 1); check($sformatf("b2b_done_%0d", f), done0, 1'b1);
      check($sformatf("b2b_decode_%0d", f), b, (f == 0) ? 8'h41 : 8'h42);
    end
    wait_to(e + 1 + 2 * FL0 + 5);

    // backpressure: 1 in flight + DEPTH queued before the first tx_done
    @(posedge clk); #1;
    in_valid = 1'b1;
    acc = 0;
    repeat (300) begin
      @(negedge clk);
      if (rdy0) acc++;
      @(posedge clk); #1;
      in_data = in_data + 8'd1;
    end
    check("bp_accepted", acc, 5);
    check("bp_level_full", lvl0, 3'd4);
    check("bp_not_ready", rdy0, 1'b0);
    repeat (2200) begin
      @(posedge clk); #1;
      in_data = in_data + 8'd1;
    end
    in_valid = 1'b0;
    wait_to(cyc + 6 * FL0 + 10);
    check("bp_drained", busy0, 1'b0);

    // reset during data bit 3 of 0xA5 with two bytes queued
    push(8'hA5, e);
    push(8'h11, s);
    push(8'h22, s);
    wait_to(e + 1 + 4 * C0 + 50);
    check("rst_queued", lvl0, 3'd2);
    @(posedge clk); #1;
    resetn = 1'b0;
    @(posedge clk); #1;
    check("rst_line_idle", ser0, 1'b1);
    check("rst_flushed", lvl0, 3'd0);
    check("rst_no_done", done0, 1'b0);
    check("rst_not_ready", rdy0, 1'b0);
    resetn = 1'b1;
    repeat (2500) @(posedge clk); #1;
    check("rst_quiet", {busy0, ser0}, 2'b01);

    // randomized traffic with occasional resets
    repeat (20000) begin
      @(posedge clk); #1;
      in_valid = ($urandom_range(0, 9) == 0);
      in_data  = 8'($urandom);
      resetn   = ($urandom_range(0, 4999) != 0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    resetn   = 1'b1;
    wait_to(cyc + 6 * FL0 + 10);
    check("final_idle", {busy1, busy0}, 2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_driver.md
Name: uart_tx_driver

Overview:
- Serial 8N1 transmitter that drives the chip's ser_rx pin.
- Counterpart to the bench-side ser_tx receiver/monitor: lets the team inject command bytes (PINs, test selectors) into the SoC UART.
- Contains a small byte FIFO fed by a valid/ready producer and a baud-divided shift FSM.
- Same clock domain as the SoC clk.

Parameters:
- CLKS_PER_BIT, 106, clk cycles per serial bit (2 x 53 half-period); must be >= 2.
- FIFO_DEPTH, 4, byte FIFO entries; power of two, >= 2.
- FIFO_AW, 2, log2(FIFO_DEPTH); sets the fifo_level width.

Ports:
- clk  input  1  system clock; all logic on posedge.
- resetn  input  1  synchronous active-low reset.
- in_valid  input  1  producer has a byte on in_data.
- in_data  input  8  byte to transmit.
- in_ready  output  1  FIFO can accept a byte this cycle.
- ser_rx  output  1  serial line to the chip; idle high.
- busy  output  1  frame in progress, or FIFO non-empty.
- tx_done  output  1  one-cycle pulse on the last cycle of each stop bit.
- fifo_level  output  FIFO_AW+1  current FIFO occupancy, 0..FIFO_DEPTH.

Behaviour:
- Clock is clk; reset is resetn, synchronous, active-low. Reset is sampled only on posedge clk.
- Reset values:
  - ser_rx=1, in_ready=0 while resetn=0, busy=0, tx_done=0, fifo_level=0.
  - FIFO pointers zeroed, FSM in IDLE, baud and bit counters 0.
- Push and ready:
  - A byte is accepted on a posedge where in_valid && in_ready.
  - in_ready = resetn_q && (fifo_level != FIFO_DEPTH), derived from registered state only.
  - A same-cycle pop does not raise in_ready while full.
- Pop:
  - In IDLE, or on the final cycle of STOP, with the FIFO non-empty, the FSM pops the head into shift register sh[7:0] and enters START.
  - Simultaneous push and pop: level unchanged, both pointers advance.
- FSM states:
  - IDLE: ser_rx=1. Moves to START when the FIFO is non-empty.
  - START: ser_rx=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: ser_rx=sh[0], LSB first. Every CLKS_PER_BIT cycles, sh shifts right and bit_cnt increments. After bit 7 completes, go to STOP (or PARITY when enabled).
  - STOP: ser_rx=1 for CLKS_PER_BIT cycles. On the final cycle, tx_done=1; the next state is START if the FIFO is non-empty, else IDLE.
- Timing:
  - A byte pushed into an empty FIFO while IDLE: the FIFO holds it at edge N; the FSM pops at edge N+1; ser_rx falls after edge N+1.
  - Frame length is exactly 10*CLKS_PER_BIT cycles.
  - Back-to-back frames have zero idle cycles between the stop bit and the next start bit.
- Baud counter: counts 0..CLKS_PER_BIT-1 and wraps to 0 at each bit boundary; it is not free-running in IDLE (held at 0).
- ser_rx is driven directly from a flop, glitch-free.
- busy = (state != IDLE) || (fifo_level != 0).
- Reset mid-frame:
  - On the first edge with resetn=0, ser_rx returns to 1 and the FIFO is flushed.
  - No partial-frame completion and no tx_done pulse.
- Pushes when in_ready=0 are ignored; in_data is not sampled.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - A PARITY state sits between DATA and STOP.
  - ser_rx = ^byte (even parity) for CLKS_PER_BIT cycles.
  - Frame = 11*CLKS_PER_BIT; tx_done timing shifts accordingly.
- Undefined:
  - No PARITY state and no parity logic; pure 8N1.

Test Plan:
- Single byte, CLKS_PER_BIT=106: push 0x55 at cycle 0 -> ser_rx=0 over cycles 1..106. Data bits follow 1,0,1,0,1,0,1,0, each 106 cycles. Stop bit high. tx_done pulses at cycle 1060; busy=0 at cycle 1061.
- Back-to-back: push 0x41 then 0x42 on consecutive cycles -> second start bit begins on the cycle immediately after the first frame's tx_done. Monitor decodes 'A','B'.
- Backpressure: hold in_valid=1 with incrementing data -> 5 bytes accepted (1 in flight + 4 in FIFO). in_ready=0 and fifo_level=4 until the first tx_done. Exactly one further byte is accepted after each tx_done.
- Reset mid-frame: assert resetn=0 during DATA bit 3 of 0xA5 with 2 bytes queued -> after that edge, ser_rx=1 and fifo_level=0. No tx_done pulse. After release, the line stays idle with no stray frames.
- Minimum divider, CLKS_PER_BIT=2: push 0x00 -> start bit plus 8 zero bits = 18 low cycles, then 2 high cycles. tx_done at cycle 20.
- UART_TX_PARITY_EN, CLKS_PER_BIT=106: push 0x07 -> parity bit 1 during cycles 955..1060. Stop bit follows; tx_done at cycle 1166.
